// File: rtl/pwm_setting_pkg.sv
// -----------------------------------------------------------------------------
// pwm_setting_pkg
// Shared definitions for the PWM setting front end: the 4-bit step type, the
// legal range and reset value of the frequency step (bf) and duty step (bc),
// and the bounded up/down step function used by both counters.
// -----------------------------------------------------------------------------
package pwm_setting_pkg;

    typedef logic [3:0] step_t;

    localparam step_t BF_MIN = 4'd1;
    localparam step_t BF_MAX = 4'd8;
    localparam step_t BF_RST = 4'd1;

    localparam step_t BC_MIN = 4'd0;
    localparam step_t BC_MAX = 4'd10;
    localparam step_t BC_RST = 4'd5;

    // One step of a bounded counter. An out-of-range value recovers to the
    // reset value on the next press. At a bound the value either holds or,
    // when wrap is set, jumps to the opposite bound.
    function automatic step_t step_bounded(
        input step_t cur,
        input logic  legal,
        input logic  up,
        input step_t lo,
        input step_t hi,
        input step_t rst_val,
        input logic  wrap
    );
        step_t nxt;
        if (!legal) begin
            nxt = rst_val;
        end else if (up) begin
            if (cur == hi) nxt = wrap ? lo : hi;
            else           nxt = cur + 4'd1;
        end else begin
            if (cur == lo) nxt = wrap ? hi : lo;
            else           nxt = cur - 4'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// -----------------------------------------------------------------------------
// button_debouncer
// Synchronises a raw bouncing push-button, debounces it and emits a single
// clock pulse on each accepted press (rising debounced level). Releases are
// debounced the same way but produce no pulse.
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive stable synchronised cycles needed to accept a
//                    level change (minimum 2)
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-high reset
//   btn_raw      raw asynchronous button level, high = pressed
//   press_pulse  one-cycle pulse per accepted press
// -----------------------------------------------------------------------------
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic press_pulse
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             s;
    logic             db;
    logic             db_d;
    logic [CNT_W-1:0] cnt;

    // NOTE: every register here is updated with non-blocking assignments so
    // the synchroniser stages and db_d all see the pre-edge value of their
    // source, giving true one-cycle delays regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            s     <= 1'b0;
            db    <= 1'b0;
            db_d  <= 1'b0;
            cnt   <= '0;
        end else begin
            sync1 <= btn_raw;
            s     <= sync1;
            db_d  <= db;
            if (s != db) begin
                if (cnt == CNT_LAST) begin
                    db  <= s;
                    cnt <= '0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else begin
                // Any bounce back to the accepted level restarts the count.
                cnt <= '0;
            end
        end
    end

    // db and db_d both clear on reset, so deassertion cannot create a pulse.
    assign press_pulse = db & ~db_d;

endmodule

// File: rtl/pwm_setting_counter.sv
// -----------------------------------------------------------------------------
// pwm_setting_counter
// Turns two raw push-buttons into the frequency step bf (1..8) and the duty
// step bc (0..10, tens of percent). opcion selects which count the buttons
// edit; each debounced press moves the selected count by one step.
//
// Build option: define PWM_SETTING_WRAP_EN to wrap at the range ends instead
// of saturating.
//
// Parameters:
//   DEBOUNCE_CYCLES  debounce length in clk cycles (minimum 2)
// Ports:
//   clk       system clock, rising edge
//   reset     asynchronous active-high reset
//   btn_up    raw up button, high = pressed
//   btn_down  raw down button, high = pressed
//   opcion    1 = edit bf, 0 = edit bc
//   bf        frequency step, registered
//   bc        duty step, registered
// -----------------------------------------------------------------------------
module pwm_setting_counter
    import pwm_setting_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       opcion,
    output logic [3:0] bf,
    output logic [3:0] bc
);

`ifdef PWM_SETTING_WRAP_EN
    localparam logic WRAP = 1'b1;
`else
    localparam logic WRAP = 1'b0;
`endif

    logic p_up;
    logic p_down;
    logic bf_legal;
    logic bc_legal;

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_up (
        .clk         (clk),
        .reset       (reset),
        .btn_raw     (btn_up),
        .press_pulse (p_up)
    );

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_down (
        .clk         (clk),
        .reset       (reset),
        .btn_raw     (btn_down),
        .press_pulse (p_down)
    );

    // bc's lower bound is 0, so only the upper bound needs checking.
    assign bf_legal = (bf >= BF_MIN) && (bf <= BF_MAX);
    assign bc_legal = (bc <= BC_MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bf <= BF_RST;
            bc <= BC_RST;
        end else if (p_up ^ p_down) begin
            // Coincident up and down pulses cancel; only one direction steps.
            if (opcion) bf <= step_bounded(bf, bf_legal, p_up, BF_MIN, BF_MAX, BF_RST, WRAP);
            else        bc <= step_bounded(bc, bc_legal, p_up, BC_MIN, BC_MAX, BC_RST, WRAP);
        end
    end

endmodule

// File: tb/tb_pwm_setting_counter.sv
// -----------------------------------------------------------------------------
// tb_pwm_setting_counter
// Directed bench for pwm_setting_counter with DEBOUNCE_CYCLES = 4. A reference
// model derived from the behavioural rules (two-stage synchroniser, "accept a
// level after D consecutive differing samples since the last change", rising
// edge pulse, bounded step) is compared against bf/bc on every falling edge;
// literal expectations along the directed sequence pin the model.
// -----------------------------------------------------------------------------
module tb_pwm_setting_counter;

    localparam int D = 4;
`ifdef PWM_SETTING_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       btn_up = 1'b0;
    logic       btn_down = 1'b0;
    logic       opcion = 1'b0;
    logic [3:0] bf;
    logic [3:0] bc;

    int n_vec  = 0;
    int n_miss = 0;

    pwm_setting_counter #(.DEBOUNCE_CYCLES(D)) dut (
        .clk      (clk),
        .reset    (reset),
        .btn_up   (btn_up),
        .btn_down (btn_down),
        .opcion   (opcion),
        .bf       (bf),
        .bc       (bc)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int m_bf = 1;
    int m_bc = 5;
    bit m_sync1[2];
    bit m_sync2[2];
    bit m_db[2];
    bit m_p[2];
    bit win[2][$];   // synchronised samples seen since the last accepted change

    function automatic int step(input int v, input bit up, input int lo, input int hi);
        if (up) return (v == hi) ? (WRAP ? lo : hi) : v + 1;
        else    return (v == lo) ? (WRAP ? hi : lo) : v - 1;
    endfunction

    initial begin
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                m_bf = 1;
                m_bc = 5;
                for (int b = 0; b < 2; b++) begin
                    m_sync1[b] = 0; m_sync2[b] = 0; m_db[b] = 0; m_p[b] = 0;
                    win[b].delete();
                end
            end else begin
                bit raw[2];
                raw[0] = btn_up;
                raw[1] = btn_down;
                // Pulses present before this edge act on the count now.
                if (m_p[0] != m_p[1]) begin
                    if (opcion) m_bf = step(m_bf, m_p[0], 1, 8);
                    else        m_bc = step(m_bc, m_p[0], 0, 10);
                end
                for (int b = 0; b < 2; b++) begin
                    bit s_now;
                    bit accept;
                    s_now = m_sync2[b];
                    m_sync2[b] = m_sync1[b];
                    m_sync1[b] = raw[b];
                    win[b].push_back(s_now);
                    if (win[b].size() > D) void'(win[b].pop_front());
                    accept = (win[b].size() == D);
                    foreach (win[b][k]) if (win[b][k] == m_db[b]) accept = 0;
                    m_p[b] = accept && !m_db[b];
                    if (accept) begin
                        m_db[b] = !m_db[b];
                        win[b].delete();
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            check("model_bf", int'(bf), m_bf);
            check("model_bc", int'(bc), m_bc);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input bit up, input bit dn);
        btn_up = up;
        btn_down = dn;
        tick(D + 4);
        btn_up = 1'b0;
        btn_down = 1'b0;
        tick(D + 4);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
    endtask

    initial begin
        #2 reset = 1'b1;
        tick(3);

        // 1: reset release, idle
        reset = 1'b0;
        tick(10);
        check("idle_bf", int'(bf), 1);
        check("idle_bc", int'(bc), 5);

        // 2: clean up press, bf steps exactly at edge D+3
        do_reset();
        opcion = 1'b1;
        btn_up = 1'b1;
        tick(6);
        check("lat_edge6_bf", int'(bf), 1);
        tick(1);
        check("lat_edge7_bf", int'(bf), 2);
        tick(13);
        check("held_bf", int'(bf), 2);
        btn_up = 1'b0;
        tick(10);
        check("released_bf", int'(bf), 2);
        check("released_bc", int'(bc), 5);

        // 3: bouncing input is rejected, then saturate/wrap at the top
        for (int i = 0; i < 10; i++) begin
            btn_up = (i % 2 == 0);
            tick(1);
        end
        btn_up = 1'b0;
        tick(8);
        check("bounce_bf", int'(bf), 2);
        for (int i = 0; i < 6; i++) press(1'b1, 1'b0);
        check("up6_bf", int'(bf), 8);
        press(1'b1, 1'b0);
        check("up7_bf", int'(bf), WRAP ? 1 : 8);
        check("up7_bc", int'(bc), 5);

        // 4: duty down to the bottom
        opcion = 1'b0;
        for (int i = 0; i < 5; i++) press(1'b0, 1'b1);
        check("dn5_bc", int'(bc), 0);
        press(1'b0, 1'b1);
        check("dn6_bc", int'(bc), WRAP ? 10 : 0);

        // 5: coincident up and down cancel
        do_reset();
        btn_up = 1'b1;
        btn_down = 1'b1;
        tick(D + 4);
        check("both_bc", int'(bc), 5);
        check("both_bf", int'(bf), 1);
        btn_up = 1'b0;
        btn_down = 1'b0;
        tick(10);

        // 6: opcion change and reset while a press is in progress
        opcion = 1'b1;
        btn_up = 1'b1;
        tick(3);
        opcion = 1'b0;
        tick(1);
        reset = 1'b1;
        tick(1);
        check("midrst_bf", int'(bf), 1);
        check("midrst_bc", int'(bc), 5);
        reset = 1'b0;
        tick(6);
        check("redeb_edge6_bc", int'(bc), 5);
        tick(1);
        check("redeb_edge7_bc", int'(bc), 6);
        check("redeb_bf", int'(bf), 1);
        btn_up = 1'b0;
        tick(10);
        check("final_bc", int'(bc), 6);

        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/pwm_setting_counter.md
Name: pwm_setting_counter

Overview:
- Upstream stage of the 7-segment constant decoder: turns two raw push-buttons (up/down) into the frequency-step count `bf` and the duty-step count `bc`.
- `opcion` selects which count the buttons edit. The same signal also drives the downstream decoder's mode select.
- Each button is synchronised, debounced and edge-detected. Each accepted press moves the selected count by exactly one step, bounded to its legal range.

Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive synchronised-stable clk cycles needed to accept a button level change (10 ms at 50 MHz); minimum 2.

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- btn_up  input  1  raw, asynchronous, bouncing button; high = pressed.
- btn_down  input  1  raw, asynchronous, bouncing button; high = pressed.
- opcion  input  1  1 = buttons edit `bf` (frequency); 0 = buttons edit `bc` (duty).
- bf  output  4  frequency step, legal range 1..8, registered.
- bc  output  4  duty step in tens of percent, legal range 0..10, registered.

Behaviour:
- Reset (async assert, sync-style deassert handled by the flops themselves):
  - bf=1, bc=5.
  - Synchroniser flops, debounce counters and debounced levels all 0.
  - No press pulse may be generated by reset deassertion.
- Per button, in this order:
  - 2-flop synchroniser produces s.
  - Debounce counter cnt, width $clog2(DEBOUNCE_CYCLES).
  - Each edge with s != db: if cnt == DEBOUNCE_CYCLES-1 then db <= s and cnt <= 0; else cnt <= cnt+1.
  - Each edge with s == db: cnt <= 0, so any bounce restarts the count.
  - db_d <= db every edge; press pulse p = db & ~db_d, high exactly one cycle.
- Latency: btn high first sampled at edge 1 and held clean → p high after edge D+2 → bf/bc updated at edge D+3 (D = DEBOUNCE_CYCLES).
- Release is debounced the same way but generates no action. Holding a button yields exactly one step.
- Counter update on the edge following p, target chosen by `opcion` sampled on that edge:
  - p_up only: target +1 unless it is at its max (bf=8, bc=10); at max it holds.
  - p_down only: target -1 unless it is at its min (bf=1, bc=0); at min it holds.
  - p_up and p_down in the same cycle: no change.
  - The non-selected count never changes.
- Changing `opcion` while a button is held or being debounced does not cancel the press. The pulse applies to whichever count `opcion` selects at the update edge.
- Illegal register values are unreachable. If bf is ever outside 1..8 or bc outside 10, the next press of either direction loads the reset value (bf=1 / bc=5) for the target.
- Reset mid-debounce: all progress is discarded; a button still held after reset must complete a full D-cycle debounce, then produces a pulse.

Optional Feature:
- PWM_SETTING_WRAP_EN defined:
  - Up at max wraps to min (bf 8→1, bc 10→0).
  - Down at min wraps to max (bf 1→8, bc 0→10).
- Undefined: saturating behaviour as above.

Decomposition:
- Shared package `pwm_setting_pkg`: BF_MIN=1, BF_MAX=8, BF_RST=1, BC_MIN=0, BC_MAX=10, BC_RST=5, and the 4-bit step type.
- Sub-module `button_debouncer` (params DEBOUNCE_CYCLES; ports clk, reset, btn_raw, press_pulse), instantiated twice.
- The top level holds only the two bounded up/down counters and the mode steering.

Test Plan (DEBOUNCE_CYCLES=4):
1. Reset released, no buttons → bf=1, bc=5 indefinitely; no pulse at deassertion.
2. opcion=1, btn_up high for 20 cycles starting at edge 1 → bf=1 until edge 6, bf=2 from edge 7, stays 2 while held and after release; bc stays 5.
3. opcion=1, btn_up pulses toggling 1,0,1,0 each cycle for 10 cycles, then steady low → no change. Then 7 clean presses from bf=2 → bf saturates at 8, with the last press ignored (wrap build: bf=1).
4. opcion=0, six clean btn_down presses from bc=5 → bc=0 after the fifth press, 0 after the sixth (wrap build: 10).
5. btn_up and btn_down raised in the same cycle, both clean, opcion=0 → pulses coincide, bc unchanged at 5.
6. opcion=1, btn_up held; opcion driven to 0 at edge 4; reset pulsed at edge 5 while btn_up is still held:
   - After reset: bf=1, bc=5.
   - The held button completes a fresh 4-cycle debounce → bc=6 (opcion=0); bf stays 1.
